// File: rtl/alu_acc_seq.sv
// Accumulator command sequencer driving an external 4-bit ALU.
// Single-cycle ALU ops plus a 4-iteration shift-add multiply through the ALU adder.
module alu_acc_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic       alu_cin,
    output logic [1:0] alu_sel,
    input  logic [3:0] alu_sum,
    input  logic       alu_cout,
    input  logic [3:0] alu_and,
    input  logic [3:0] alu_xor,
    input  logic [3:0] alu_not,
    output logic [3:0] acc,
    output logic [3:0] hi,
    output logic       carry,
    output logic       zero,
    output logic       res_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADC  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_CLR  = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic [1:0] r_state;
    logic [2:0] r_op;
    logic [3:0] r_opd;   // operand; doubles as the low product nibble during MUL
    logic [3:0] r_ph;
    logic [1:0] r_k;
    logic [3:0] r_acc;
    logic [3:0] r_hi;
    logic       r_carry;
    logic       r_res_valid;

    logic [3:0] w_exec_res;
    logic [3:0] w_ph_next;
    logic [3:0] w_pl_next;

    assign cmd_ready = rst_n && (r_state == S_IDLE);
    assign acc       = r_acc;
    assign hi        = r_hi;
    assign carry     = r_carry;
    assign res_valid = r_res_valid;
    assign zero      = (r_acc == 4'd0);

    // Multiplicand is the accumulator itself: it is frozen until the final MUL edge.
    assign w_ph_next = {alu_cout, alu_sum[3:1]};
    assign w_pl_next = {alu_sum[0], r_opd[3:1]};

    // ALU operand and select drive per state
    always_comb begin
        alu_a   = r_acc;
        alu_b   = 4'd0;
        alu_cin = 1'b0;
        alu_sel = 2'b00;
        case (r_state)
            S_IDLE: begin
                alu_a = r_acc;
            end
            S_EXEC: begin
                alu_b   = r_opd;
                alu_cin = (r_op == OP_ADC) ? r_carry : 1'b0;
                case (r_op)
                    OP_AND:  alu_sel = 2'b01;
                    OP_XOR:  alu_sel = 2'b10;
                    OP_NOT:  alu_sel = 2'b11;
                    default: alu_sel = 2'b00;
                endcase
            end
            S_MUL: begin
                alu_a = r_ph;
                alu_b = r_opd[0] ? r_acc : 4'd0;
            end
            default: begin
                alu_a = r_acc;
            end
        endcase
    end

    // Accumulator value produced by a single-cycle command
    always_comb begin
        w_exec_res = r_acc;
        case (r_op)
            OP_LOAD:        w_exec_res = r_opd;
            OP_ADD, OP_ADC: w_exec_res = alu_sum;
            OP_AND:         w_exec_res = alu_and;
            OP_XOR:         w_exec_res = alu_xor;
            OP_NOT:         w_exec_res = alu_not;
            OP_CLR:         w_exec_res = 4'd0;
            default:        w_exec_res = r_acc;
        endcase
    end

    // Sequencer state, accumulator and flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 3'd0;
            r_opd       <= 4'd0;
            r_ph        <= 4'd0;
            r_k         <= 2'd0;
            r_acc       <= 4'd0;
            r_hi        <= 4'd0;
            r_carry     <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_opd   <= cmd_data;
                        r_ph    <= 4'd0;
                        r_k     <= 2'd0;
                        r_state <= (cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    r_acc <= w_exec_res;
                    case (r_op)
                        OP_ADD, OP_ADC: r_carry <= alu_cout;
                        OP_LOAD, OP_CLR: begin
                            r_carry <= 1'b0;
                            r_hi    <= 4'd0;
                        end
                        default: r_carry <= r_carry;
                    endcase
                    r_res_valid <= 1'b1;
                    r_state     <= S_IDLE;
                end
                S_MUL: begin
                    r_ph  <= w_ph_next;
                    r_opd <= w_pl_next;
                    r_k   <= r_k + 2'd1;
                    if (r_k == 2'd3) begin
                        r_hi        <= w_ph_next;
                        r_acc       <= w_pl_next;
                        r_carry     <= (w_ph_next != 4'd0);
                        r_res_valid <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_MUL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Directed table-driven bench for alu_acc_seq with a behavioural 4-bit ALU.
module tb_alu_acc_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] alu_a, alu_b;
    logic       alu_cin;
    logic [1:0] alu_sel;
    logic [3:0] alu_sum, alu_and, alu_xor, alu_not;
    logic       alu_cout;
    logic [3:0] acc, hi;
    logic       carry, zero, res_valid;

    int errors = 0;
    int checks = 0;

    alu_acc_seq dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
        .alu_sum(alu_sum), .alu_cout(alu_cout), .alu_and(alu_and),
        .alu_xor(alu_xor), .alu_not(alu_not),
        .acc(acc), .hi(hi), .carry(carry), .zero(zero), .res_valid(res_valid)
    );

    // External ALU model
    assign {alu_cout, alu_sum} = 5'(alu_a) + 5'(alu_b) + 5'(alu_cin);
    assign alu_and = alu_a & alu_b;
    assign alu_xor = alu_a ^ alu_b;
    assign alu_not = ~alu_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [3:0] data;
        logic [3:0] e_acc;
        logic [3:0] e_hi;
        logic       e_c;
        logic       e_z;
        int         e_lat;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and return the number of edges from accept to res_valid.
    task automatic do_cmd(input logic [2:0] op, input logic [3:0] data, output int lat);
        int w;
        w = 0;
        while (!cmd_ready && w < 10) begin
            step();
            w++;
        end
        if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        step();
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_data  = ~data;
        chk("ready_low_busy", 32'(cmd_ready), 32'd0);
        lat = 99;
        for (int n = 1; n <= 10; n++) begin
            if (res_valid) begin
                lat = n - 1;
                break;
            end
            step();
        end
        if (lat == 0) lat = 99;
    endtask

    initial begin
        int lat;
        int pulses;
        int busy;
        int idx;
        logic accepted;
        logic [2:0] b_op[6];
        logic [3:0] b_data[6];

        vecs[0]  = '{3'd0, 4'h5, 4'h5, 4'h0, 1'b0, 1'b0, 1};
        vecs[1]  = '{3'd6, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1};
        vecs[2]  = '{3'd0, 4'h9, 4'h9, 4'h0, 1'b0, 1'b0, 1};
        vecs[3]  = '{3'd1, 4'h8, 4'h1, 4'h0, 1'b1, 1'b0, 1};
        vecs[4]  = '{3'd2, 4'h2, 4'h4, 4'h0, 1'b0, 1'b0, 1};
        vecs[5]  = '{3'd0, 4'hC, 4'hC, 4'h0, 1'b0, 1'b0, 1};
        vecs[6]  = '{3'd1, 4'h4, 4'h0, 4'h0, 1'b1, 1'b1, 1};
        vecs[7]  = '{3'd0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1};
        vecs[8]  = '{3'd1, 4'hD, 4'hC, 4'h0, 1'b1, 1'b0, 1};
        vecs[9]  = '{3'd3, 4'hA, 4'h8, 4'h0, 1'b1, 1'b0, 1};
        vecs[10] = '{3'd4, 4'hF, 4'h7, 4'h0, 1'b1, 1'b0, 1};
        vecs[11] = '{3'd5, 4'h5, 4'h8, 4'h0, 1'b1, 1'b0, 1};
        vecs[12] = '{3'd0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1};
        vecs[13] = '{3'd7, 4'hF, 4'h1, 4'hE, 1'b1, 1'b0, 4};
        vecs[14] = '{3'd0, 4'h3, 4'h3, 4'h0, 1'b0, 1'b0, 1};
        vecs[15] = '{3'd7, 4'h5, 4'hF, 4'h0, 1'b0, 1'b0, 4};
        vecs[16] = '{3'd0, 4'h7, 4'h7, 4'h0, 1'b0, 1'b0, 1};
        vecs[17] = '{3'd7, 4'h9, 4'hF, 4'h3, 1'b1, 1'b0, 4};
        vecs[18] = '{3'd2, 4'h1, 4'h1, 4'h3, 1'b1, 1'b0, 1};
        vecs[19] = '{3'd6, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1};
        vecs[20] = '{3'd0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1};
        vecs[21] = '{3'd7, 4'h7, 4'h0, 4'h0, 1'b0, 1'b1, 4};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0;
        step();
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("rst_acc", 32'(acc), 32'd0);
        chk("rst_hi", 32'(hi), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 22; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].e_lat));
            chk($sformatf("v%0d_acc", i), 32'(acc), 32'(vecs[i].e_acc));
            chk($sformatf("v%0d_hi", i), 32'(hi), 32'(vecs[i].e_hi));
            chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].e_c));
            chk($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].e_z));
            step();
            chk($sformatf("v%0d_pulse_end", i), 32'(res_valid), 32'd0);
        end

        // Back-to-back with cmd_valid held high: LOAD 2, ADD 3, MUL 3, XOR 1, NOT, ADD 1
        b_op   = '{3'd0, 3'd1, 3'd7, 3'd4, 3'd5, 3'd1};
        b_data = '{4'h2, 4'h3, 4'h3, 4'h1, 4'h0, 4'h1};
        idx = 0; pulses = 0; busy = 0;
        cmd_valid = 1'b1; cmd_op = b_op[0]; cmd_data = b_data[0];
        for (int c = 0; c < 30; c++) begin
            accepted = cmd_valid && cmd_ready;
            step();
            if (res_valid) pulses++;
            if (accepted) begin
                busy = (cmd_op == 3'd7) ? 4 : 1;
                idx++;
                if (idx < 6) begin
                    cmd_op = b_op[idx]; cmd_data = b_data[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (busy > 0) begin
                chk($sformatf("b2b_ready_low_c%0d", c), 32'(cmd_ready), 32'd0);
                busy--;
            end
        end
        cmd_valid = 1'b0;
        chk("b2b_accepted", 32'(idx), 32'd6);
        chk("b2b_pulses", 32'(pulses), 32'd6);
        chk("b2b_acc", 32'(acc), 32'h2);
        chk("b2b_hi", 32'(hi), 32'h0);

        // Reset during the second MUL iteration
        do_cmd(3'd0, 4'h7, lat);
        chk("pre_mul_acc", 32'(acc), 32'h7);
        step();
        cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = 4'h3;
        step();
        cmd_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        chk("midmul_rst_res_valid", 32'(res_valid), 32'd0);
        chk("midmul_rst_ready", 32'(cmd_ready), 32'd0);
        rst_n = 1'b1;
        chk("midmul_acc", 32'(acc), 32'd0);
        chk("midmul_hi", 32'(hi), 32'd0);
        chk("midmul_carry", 32'(carry), 32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (res_valid) pulses++;
        end
        chk("midmul_no_pulse", 32'(pulses), 32'd0);
        chk("midmul_acc_held", 32'(acc), 32'd0);
        do_cmd(3'd0, 4'h6, lat);
        chk("post_rst_lat", 32'(lat), 32'd1);
        chk("post_rst_acc", 32'(acc), 32'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
